// File: rtl/dht_uart_pkg.sv
// Shared definitions for the DHT11 response path: FSM encodings, UART framing,
// response-word field offsets and status codes (also used by the controller and PC decoder).
package dht_uart_pkg;

  localparam int UART_DATA_BITS = 8;

  localparam int ADDR_LSB = 0;
  localparam int CODE_LSB = 5;
  localparam int DATA_LSB = 9;

  localparam logic [3:0] CODE_OK         = 4'b1001;
  localparam logic [3:0] CODE_HUMIDITY   = 4'b1010;
  localparam logic [3:0] CODE_TEMP       = 4'b1011;
  localparam logic [3:0] CODE_CONT_OFF_H = 4'b1100;
  localparam logic [3:0] CODE_CONT_OFF_T = 4'b1101;
  localparam logic [3:0] CODE_ERROR      = 4'b1111;

  // Bit-level serialiser states and word-level sequencing states.
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} bit_state_t;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_ACK, W_WAIT_LOW} word_state_t;

  function automatic logic [15:0] pack_resp(input logic [6:0] data,
                                            input logic [3:0] code,
                                            input logic [4:0] addr);
    logic [15:0] w;
    w = '0;
    w[DATA_LSB +: 7] = data;
    w[CODE_LSB +: 4] = code;
    w[ADDR_LSB +: 5] = addr;
    return w;
  endfunction

endpackage

// File: rtl/dht_resp_uart_tx_if.sv
// Handshake between the DHT11 controller (master) and the response UART stage (slave).
interface dht_resp_uart_tx_if;
  logic        buffer_pronto;
  logic [15:0] info;
  logic        buffer_usado;
  logic        busy;

  modport master (output buffer_pronto, info, input buffer_usado, busy);
  modport slave  (input buffer_pronto, info, output buffer_usado, busy);
endinterface

// File: rtl/uart_tx_byte.sv
// One 8N1 UART byte per load; a load during the last stop-bit clock chains the next
// byte with no idle gap. done is high during that last stop-bit clock.
module uart_tx_byte
  import dht_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST = 3'(UART_DATA_BITS - 1);

  bit_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == S_IDLE || bit_end) ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          state_d = S_START;
          sh_d    = data;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = sh_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_LAST) begin
            state_d = S_STOP;
            bit_d   = '0;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = sh_q >> 1;
            tx_d  = sh_q[1];
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          done = 1'b1;
          if (load) begin
            state_d = S_START;
            sh_d    = data;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx = tx_q;

endmodule

// File: rtl/dht_resp_uart_tx.sv
// Captures the controller's 16-bit response word and sends it as two back-to-back UART
// bytes (low first), then pulses buffer_usado and waits for buffer_pronto to drop.
module dht_resp_uart_tx
  import dht_uart_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic              clk,
  input  logic              rst_n,
  dht_resp_uart_tx_if.slave resp,
  output logic              tx
);

  word_state_t state_q, state_d;
  logic [15:0] word_q;
  logic        byte_sel_q;
  logic        first_q;
  logic        usado_q;
  logic        busy_q;
  logic        capture;
  logic        byte_done;
  logic        byte_load;
  logic [7:0]  byte_data;

  assign capture = (state_q == W_IDLE) && resp.buffer_pronto;

  // The first byte is launched one clock after capture so word_q is settled; the second
  // is chained in the last stop-bit clock of the first so there is no gap on the line.
  assign byte_load = first_q || (byte_done && !byte_sel_q);
  assign byte_data = (byte_sel_q || byte_done) ? word_q[15:8] : word_q[7:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      W_IDLE:     if (resp.buffer_pronto) state_d = W_SEND;
      W_SEND:     if (byte_done && byte_sel_q) state_d = W_ACK;
      W_ACK:      state_d = W_WAIT_LOW;
      W_WAIT_LOW: if (!resp.buffer_pronto) state_d = W_IDLE;
      default:    state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= W_IDLE;
      word_q     <= '0;
      byte_sel_q <= 1'b0;
      first_q    <= 1'b0;
      usado_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= capture;
      usado_q <= (state_q == W_ACK);
      busy_q  <= (state_d != W_IDLE);
      if (capture) begin
        word_q     <= resp.info;
        byte_sel_q <= 1'b0;
      end else if (byte_done && !byte_sel_q) begin
        byte_sel_q <= 1'b1;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk  (clk),
    .rst_n(rst_n),
    .load (byte_load),
    .data (byte_data),
    .tx   (tx),
    .done (byte_done)
  );

  assign resp.buffer_usado = usado_q;
  assign resp.busy         = busy_q;

endmodule
